// File: rtl/fb_scanout_prefetch_pkg.sv
// Shared SDRAM command encodings and framebuffer geometry for the scanout read path
// and the pixel writer.
package fb_scanout_prefetch_pkg;

  localparam logic [1:0] CMD_IDLE  = 2'd0;
  localparam logic [1:0] CMD_READ  = 2'd1;
  localparam logic [1:0] CMD_WRITE = 2'd2;

  localparam int unsigned READ_BURST_LENGTH = 8;

  localparam int unsigned FB_WIDTH  = 480;
  localparam int unsigned FB_HEIGHT = 200;
  localparam int unsigned FB_WORDS  = FB_WIDTH * FB_HEIGHT;
  localparam int unsigned FB_BASE   = 0;

  localparam int unsigned ADDR_W = 22;
  localparam int unsigned DATA_W = 32;

  typedef enum logic [1:0] {StIdle, StRead, StDrain} state_e;

endpackage

// File: rtl/fb_scanout_prefetch_if.sv
// Bundle of SDRAM-controller, arbitration, frame-timing and pixel-stream signals.
// The master modport is the prefetcher's view; slave is the surrounding system.
interface fb_scanout_prefetch_if #(
  parameter int unsigned LEVEL_W = 6
);
  import fb_scanout_prefetch_pkg::*;

  logic              i_Data_Read_Valid;
  logic [DATA_W-1:0] i_Data_Read;
  logic              i_SDRAM_Requested;
  logic              o_SDRAM_Yield;
  logic [1:0]        o_Command;
  logic [ADDR_W-1:0] o_Data_Address;
  logic              i_Frame_Start;
  logic [DATA_W-1:0] o_Pixel_Data;
  logic              o_Pixel_Valid;
  logic              i_Pixel_Ready;
  logic [LEVEL_W-1:0] o_Fifo_Level;
  logic              o_Underflow;

  modport master (
    input  i_Data_Read_Valid, i_Data_Read, i_SDRAM_Requested, i_Frame_Start, i_Pixel_Ready,
    output o_SDRAM_Yield, o_Command, o_Data_Address, o_Pixel_Data, o_Pixel_Valid,
           o_Fifo_Level, o_Underflow
  );

  modport slave (
    output i_Data_Read_Valid, i_Data_Read, i_SDRAM_Requested, i_Frame_Start, i_Pixel_Ready,
    input  o_SDRAM_Yield, o_Command, o_Data_Address, o_Pixel_Data, o_Pixel_Valid,
           o_Fifo_Level, o_Underflow
  );

endinterface

// File: rtl/fb_scanout_prefetch_sync_fifo.sv
// First-word-fall-through synchronous FIFO with flush and occupancy output.
// Depth must be a power of two so the pointers wrap naturally.
module fb_scanout_prefetch_sync_fifo #(
  parameter int unsigned Width = 32,
  parameter int unsigned Depth = 32,
  localparam int unsigned PtrW   = $clog2(Depth),
  localparam int unsigned LevelW = PtrW + 1
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              flush_i,
  input  logic              push_i,
  input  logic [Width-1:0]  wdata_i,
  input  logic              pop_i,
  output logic [Width-1:0]  rdata_o,
  output logic              valid_o,
  output logic [LevelW-1:0] level_o
);

  logic [Width-1:0]  mem_q [Depth];
  logic [PtrW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [LevelW-1:0] level_q;
  logic              pop_ok;

  assign pop_ok  = pop_i && (level_q != '0);
  assign rdata_o = mem_q[rd_ptr_q];
  assign valid_o = (level_q != '0);
  assign level_o = level_q;

  always_ff @(posedge clk_i) begin
    if (push_i && !flush_i) begin
      mem_q[wr_ptr_q] <= wdata_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else if (flush_i) begin
      // Flush wins over any same-cycle push or pop.
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (push_i) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (pop_ok) rd_ptr_q <= rd_ptr_q + PtrW'(1);
      if (push_i && !pop_ok) begin
        level_q <= level_q + LevelW'(1);
      end else if (!push_i && pop_ok) begin
        level_q <= level_q - LevelW'(1);
      end
    end
  end

  a_no_push_at_full: assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(push_i && (level_q == LevelW'(Depth))));

endmodule

// File: rtl/fb_scanout_prefetch.sv
// Framebuffer scanout prefetcher: issues SDRAM read bursts when the FIFO has room for a
// whole burst and streams buffered words to the LCD driver.
module fb_scanout_prefetch
  import fb_scanout_prefetch_pkg::*;
#(
  parameter int unsigned FRAME_WORDS = FB_WORDS,
  parameter int unsigned BASE_ADDR   = FB_BASE,
  parameter int unsigned BURST_LEN   = READ_BURST_LENGTH,
  parameter int unsigned FIFO_DEPTH  = 32
) (
  input logic                   i_Clk,
  input logic                   i_Rst_n,
  fb_scanout_prefetch_if.master bus
);

  localparam int unsigned LevelW = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned CntW   = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam logic [ADDR_W-1:0] BaseAddr      = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W-1:0] LastAddr      = ADDR_W'(BASE_ADDR + FRAME_WORDS - 1);
  localparam logic [LevelW-1:0] MaxStartLevel = LevelW'(FIFO_DEPTH - BURST_LEN);
  localparam logic [CntW-1:0]   CntLoad       = CntW'(BURST_LEN - 1);

  state_e            state_q;
  logic [1:0]        cmd_q;
  logic [ADDR_W-1:0] addr_q, addr_inc;
  logic [CntW-1:0]   cnt_q;
  logic              underflow_q;

  logic [LevelW-1:0] level;
  logic              fifo_valid;
  logic [DATA_W-1:0] fifo_data;
  logic              last_word, can_start, push, pop, flush;

  assign last_word = bus.i_Data_Read_Valid && (cnt_q == '0);
  assign can_start = !bus.i_SDRAM_Requested && (level <= MaxStartLevel) && !bus.i_Frame_Start;
  assign addr_inc  = (addr_q == LastAddr) ? BaseAddr : addr_q + ADDR_W'(1);

  // A word arriving on the frame-start edge already belongs to the stale frame.
  assign push  = (state_q == StRead) && bus.i_Data_Read_Valid && !bus.i_Frame_Start;
  assign pop   = fifo_valid && bus.i_Pixel_Ready;
  assign flush = ((state_q == StIdle) && bus.i_Frame_Start) ||
                 ((state_q == StDrain) && last_word) ||
                 ((state_q == StRead) && bus.i_Frame_Start && last_word);

  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      state_q     <= StIdle;
      cmd_q       <= CMD_IDLE;
      addr_q      <= BaseAddr;
      cnt_q       <= '0;
      underflow_q <= 1'b0;
    end else begin
      if (bus.i_Pixel_Ready && !fifo_valid) underflow_q <= 1'b1;
      case (state_q)
        StIdle: begin
          if (bus.i_Frame_Start) begin
            addr_q <= BaseAddr;
          end else if (can_start) begin
            state_q <= StRead;
            cmd_q   <= CMD_READ;
            cnt_q   <= CntLoad;
          end
        end
        StRead: begin
          if (bus.i_Data_Read_Valid) begin
            cnt_q  <= cnt_q - CntW'(1);
            addr_q <= addr_inc;
          end
          if (last_word) begin
            state_q <= StIdle;
            cmd_q   <= CMD_IDLE;
            if (bus.i_Frame_Start) addr_q <= BaseAddr;
          end else if (bus.i_Frame_Start) begin
            state_q <= StDrain;
          end
        end
        StDrain: begin
          if (bus.i_Data_Read_Valid) cnt_q <= cnt_q - CntW'(1);
          if (last_word) begin
            state_q <= StIdle;
            cmd_q   <= CMD_IDLE;
            addr_q  <= BaseAddr;
          end
        end
        default: begin
          state_q <= StIdle;
          cmd_q   <= CMD_IDLE;
        end
      endcase
    end
  end

  fb_scanout_prefetch_sync_fifo #(
    .Width (DATA_W),
    .Depth (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (i_Clk),
    .rst_ni  (i_Rst_n),
    .flush_i (flush),
    .push_i  (push),
    .wdata_i (bus.i_Data_Read),
    .pop_i   (pop),
    .rdata_o (fifo_data),
    .valid_o (fifo_valid),
    .level_o (level)
  );

  assign bus.o_Command      = cmd_q;
  assign bus.o_Data_Address = addr_q;
  assign bus.o_SDRAM_Yield  = bus.i_SDRAM_Requested && (cmd_q == CMD_IDLE);
  assign bus.o_Pixel_Data   = fifo_data;
  assign bus.o_Pixel_Valid  = fifo_valid;
  assign bus.o_Fifo_Level   = level;
  assign bus.o_Underflow    = underflow_q;

  a_no_write_cmd: assert property (@(posedge i_Clk) disable iff (!i_Rst_n)
    cmd_q != CMD_WRITE);

endmodule
